// File: rtl/mean_filter_sched.sv
// Round-robin scheduler that time-shares one mean filter across NUM_CH sample channels.
// Define MEAN_FILTER_SCHED_TIMEOUT_EN to abandon a frame when the filter never signals done.
module mean_filter_sched #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned WINDOW  = 10,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         req_i,
  input  logic [NUM_CH-1:0]         smp_valid_i,
  input  logic [NUM_CH*8-1:0]       smp_data_i,
  output logic [NUM_CH-1:0]         smp_ready_o,
  output logic                      flt_rst_n_o,
  output logic                      flt_en_o,
  output logic [7:0]                flt_data_o,
  input  logic                      flt_done_i,
  input  logic [7:0]                flt_data_i,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic [$clog2(NUM_CH)-1:0] res_ch_o,
  output logic [7:0]                res_data_o,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int unsigned CW = $clog2(NUM_CH);
  localparam int unsigned SW = $clog2(WINDOW + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [CW-1:0] rr_q, rr_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          flt_en_q, flt_en_d;
  logic [7:0]    flt_data_q, flt_data_d;
  logic [7:0]    res_data_q, res_data_d;
  logic [CW-1:0] res_ch_q, res_ch_d;

  logic          grant_vld;
  logic [CW-1:0] grant_ch;
  logic          sel_valid;
  logic [7:0]    sel_data;
  logic          xfer;
  logic [CW-1:0] next_ch;

`ifdef MEAN_FILTER_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  // Two-pass search: channels at/above rr_q win first, then the wrap-around pass.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    for (int unsigned j = 0; j < NUM_CH; j++) begin
      if (!grant_vld && req_i[j] && (CW'(j) >= rr_q)) begin
        grant_vld = 1'b1;
        grant_ch  = CW'(j);
      end
    end
    for (int unsigned j = 0; j < NUM_CH; j++) begin
      if (!grant_vld && req_i[j]) begin
        grant_vld = 1'b1;
        grant_ch  = CW'(j);
      end
    end
  end

  always_comb begin
    sel_valid   = 1'b0;
    sel_data    = '0;
    smp_ready_o = '0;
    for (int unsigned j = 0; j < NUM_CH; j++) begin
      if (ch_q == CW'(j)) begin
        sel_valid      = smp_valid_i[j];
        sel_data       = smp_data_i[j*8 +: 8];
        smp_ready_o[j] = (state_q == S_STREAM);
      end
    end
  end

  assign xfer    = (state_q == S_STREAM) && sel_valid;
  assign next_ch = (ch_q == CW'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    flt_en_d   = 1'b0;
    flt_data_d = flt_data_q;
    res_data_d = res_data_q;
    res_ch_d   = res_ch_q;
`ifdef MEAN_FILTER_SCHED_TIMEOUT_EN
    tmo_d      = tmo_q;
    err_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          ch_d    = grant_ch;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_STREAM;
`ifdef MEAN_FILTER_SCHED_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_STREAM: begin
        if (xfer) begin
          flt_en_d   = 1'b1;
          flt_data_d = sel_data;
          if (cnt_q == SW'(WINDOW - 1)) state_d = S_WAIT;
          else                          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (flt_done_i) begin
          res_data_d = flt_data_i;
          res_ch_d   = ch_q;
          state_d    = S_RESULT;
        end
`ifdef MEAN_FILTER_SCHED_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          rr_d    = next_ch;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      S_RESULT: begin
        if (res_ready_i) begin
          rr_d    = next_ch;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      rr_q       <= '0;
      cnt_q      <= '0;
      flt_en_q   <= 1'b0;
      flt_data_q <= '0;
      res_data_q <= '0;
      res_ch_q   <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      flt_en_q   <= flt_en_d;
      flt_data_q <= flt_data_d;
      res_data_q <= res_data_d;
      res_ch_q   <= res_ch_d;
    end
  end

`ifdef MEAN_FILTER_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // Gated by rst_n so the filter is held clear for the whole reset interval.
  assign flt_rst_n_o = rst_n && (state_q != S_CLEAR);
  assign flt_en_o    = flt_en_q;
  assign flt_data_o  = flt_data_q;
  assign res_valid_o = (state_q == S_RESULT);
  assign res_ch_o    = res_ch_q;
  assign res_data_o  = res_data_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mean_filter_sched.sv
// Directed bench for mean_filter_sched: drives inputs on the falling edge and checks there.
module tb_mean_filter_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_i;
  logic [3:0]  smp_valid_i;
  logic [31:0] smp_data_i;
  logic [3:0]  smp_ready_o;
  logic        flt_rst_n_o;
  logic        flt_en_o;
  logic [7:0]  flt_data_o;
  logic        flt_done_i;
  logic [7:0]  flt_data_i;
  logic        res_valid_o;
  logic        res_ready_i;
  logic [1:0]  res_ch_o;
  logic [7:0]  res_data_o;
  logic        busy_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;
  int clr_total = 0;
  int err_total = 0;

  mean_filter_sched #(.NUM_CH(4), .WINDOW(10), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .smp_valid_i(smp_valid_i),
    .smp_data_i(smp_data_i), .smp_ready_o(smp_ready_o), .flt_rst_n_o(flt_rst_n_o),
    .flt_en_o(flt_en_o), .flt_data_o(flt_data_o), .flt_done_i(flt_done_i),
    .flt_data_i(flt_data_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_ch_o(res_ch_o), .res_data_o(res_data_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && !flt_rst_n_o) clr_total++;
    if (err_o) err_total++;
  end

  `define CHK(TAG, OBS, EXP) \
    begin \
      checks++; \
      assert ((OBS) === (EXP)) else begin \
        errors++; \
        $error("FAIL %s observed=%0h expected=%0h", TAG, OBS, EXP); \
      end \
    end

  // Streams n samples base..base+n-1 into channel c; full frames add two trailing
  // cycles that offer one extra sample which must be refused.
  task automatic stream(input int c, input int base, input int n, input bit gappy,
                        input bit full, output int sent, output int en_cnt,
                        output int max_run, output bit ok);
    int run, guard, post, post_n;
    bit prev, tog, xfer;
    logic [3:0] onehot;
    sent = 0; en_cnt = 0; max_run = 0; ok = 1'b1;
    run = 0; guard = 0; post = 0; prev = 1'b0; tog = 1'b1;
    post_n = full ? 2 : 0;
    onehot = 4'(1) << c;
    while (guard < 100 && !(sent == n && post == post_n)) begin
      @(negedge clk);
      guard++;
      if (flt_en_o !== prev) ok = 1'b0;
      if (flt_en_o === 1'b1) begin
        if (flt_data_o !== 8'(base + en_cnt)) ok = 1'b0;
        en_cnt++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      xfer = 1'b0;
      smp_valid_i = '0;
      if (sent < n) begin
        if (smp_ready_o[c] === 1'b1) begin
          if (smp_ready_o !== onehot) ok = 1'b0;
          if (!gappy || tog) begin
            smp_valid_i[c] = 1'b1;
            smp_data_i[c*8 +: 8] = 8'(base + sent);
            sent++;
            xfer = 1'b1;
          end
          tog = !tog;
        end
      end else begin
        post++;
        if (post == 1) begin
          if (smp_ready_o !== 4'b0000) ok = 1'b0;
          smp_valid_i[c] = 1'b1;
          smp_data_i[c*8 +: 8] = 8'd99;
        end
      end
      prev = xfer;
    end
  endtask

  task automatic give_done(input logic [7:0] mean);
    flt_done_i = 1'b1;
    flt_data_i = mean;
    @(negedge clk);
    flt_done_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, en_cnt, max_run, wait_k, exp_ch;
    bit ok;
    rst_n = 1'b0; req_i = '0; smp_valid_i = '0; smp_data_i = '0;
    flt_done_i = 1'b0; flt_data_i = '0; res_ready_i = 1'b0;

    repeat (2) @(negedge clk);
    `CHK("rst_ready", smp_ready_o, 4'b0000)
    `CHK("rst_flt_rst_n", flt_rst_n_o, 1'b0)
    `CHK("rst_flt_en", flt_en_o, 1'b0)
    `CHK("rst_flt_data", flt_data_o, 8'd0)
    `CHK("rst_res_valid", res_valid_o, 1'b0)
    `CHK("rst_res_ch", res_ch_o, 2'd0)
    `CHK("rst_res_data", res_data_o, 8'd0)
    `CHK("rst_busy", busy_o, 1'b0)
    `CHK("rst_err", err_o, 1'b0)
    rst_n = 1'b1;
    @(negedge clk);
    `CHK("idle_flt_rst_n", flt_rst_n_o, 1'b1)

    // Ch0, back-to-back 1..10, stray done while IDLE, req dropped after grant
    req_i = 4'b0001; flt_done_i = 1'b1; flt_data_i = 8'd77;
    @(negedge clk);
    `CHK("clear_flt_rst_n", flt_rst_n_o, 1'b0)
    `CHK("clear_busy", busy_o, 1'b1)
    req_i = '0; flt_done_i = 1'b0;
    stream(0, 1, 10, 1'b0, 1'b1, sent, en_cnt, max_run, ok);
    `CHK("c0_sent", sent, 10)
    `CHK("c0_en_cnt", en_cnt, 10)
    `CHK("c0_en_run", max_run, 10)
    `CHK("c0_stream_ok", ok, 1'b1)
    `CHK("c0_clr_pulses", clr_total, 1)
    `CHK("c0_no_early_result", res_valid_o, 1'b0)
    give_done(8'd5);
    `CHK("c0_res_valid", res_valid_o, 1'b1)
    `CHK("c0_res_ch", res_ch_o, 2'd0)
    `CHK("c0_res_data", res_data_o, 8'd5)
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      `CHK("hold_res_valid", res_valid_o, 1'b1)
      `CHK("hold_res_data", res_data_o, 8'd5)
    end
    `CHK("hold_no_clear", clr_total, 1)
    res_ready_i = 1'b1;
    @(negedge clk);
    `CHK("c0_handshake", res_valid_o, 1'b0)

    // Ch2 with stalls every other cycle: 20..29, mean 24
    req_i = 4'b0100;
    @(negedge clk);
    req_i = '0;
    stream(2, 20, 10, 1'b1, 1'b1, sent, en_cnt, max_run, ok);
    `CHK("c2_sent", sent, 10)
    `CHK("c2_en_cnt", en_cnt, 10)
    `CHK("c2_en_run", max_run, 1)
    `CHK("c2_stream_ok", ok, 1'b1)
    give_done(8'd24);
    `CHK("c2_res_valid", res_valid_o, 1'b1)
    `CHK("c2_res_ch", res_ch_o, 2'd2)
    `CHK("c2_res_data", res_data_o, 8'd24)

    // Reset mid-stream after four samples on ch1
    @(negedge clk);
    req_i = 4'b0010;
    @(negedge clk);
    req_i = '0;
    stream(1, 50, 4, 1'b0, 1'b0, sent, en_cnt, max_run, ok);
    @(negedge clk);
    `CHK("mid_en_before_rst", flt_en_o, 1'b1)
    rst_n = 1'b0;
    smp_valid_i = '0;
    #1;
    `CHK("mid_rst_ready", smp_ready_o, 4'b0000)
    `CHK("mid_rst_flt_en", flt_en_o, 1'b0)
    `CHK("mid_rst_flt_data", flt_data_o, 8'd0)
    `CHK("mid_rst_flt_rst_n", flt_rst_n_o, 1'b0)
    `CHK("mid_rst_busy", busy_o, 1'b0)
    `CHK("mid_rst_res_data", res_data_o, 8'd0)
    @(negedge clk);
    rst_n = 1'b1;

    // All channels requesting: grants 0,1,2,3,0 from a fresh rr pointer
    req_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_ch = k % 4;
      stream(exp_ch, 1 + 10 * k, 10, 1'b0, 1'b1, sent, en_cnt, max_run, ok);
      `CHK("rr_sent", sent, 10)
      `CHK("rr_en_cnt", en_cnt, 10)
      `CHK("rr_stream_ok", ok, 1'b1)
      give_done(8'(5 + 10 * k));
      `CHK("rr_res_ch", res_ch_o, 2'(exp_ch))
      `CHK("rr_res_data", res_data_o, 8'(5 + 10 * k))
    end
    req_i = '0;
    @(negedge clk);

`ifdef MEAN_FILTER_SCHED_TIMEOUT_EN
    // rr pointer sits at 1; ch2 frame is abandoned, next grant must be ch3
    req_i = 4'b0100;
    @(negedge clk);
    req_i = '0;
    stream(2, 100, 10, 1'b0, 1'b1, sent, en_cnt, max_run, ok);
    `CHK("to_sent", sent, 10)
    wait_k = -1;
    for (int k = 2; k < 90 && wait_k < 0; k++) begin
      @(negedge clk);
      if (res_valid_o) wait_k = 1000;
      else if (err_o) wait_k = k;
    end
    `CHK("to_err_delay", wait_k, 64)
    @(negedge clk);
    `CHK("to_err_pulse", err_o, 1'b0)
    `CHK("to_err_total", err_total, 1)
    `CHK("to_idle", busy_o, 1'b0)
    req_i = 4'b1111;
    stream(3, 7, 10, 1'b0, 1'b1, sent, en_cnt, max_run, ok);
    req_i = '0;
    `CHK("to_next_sent", sent, 10)
    give_done(8'd11);
    `CHK("to_next_ch", res_ch_o, 2'd3)
    `CHK("to_next_data", res_data_o, 8'd11)
`else
    `CHK("no_err_pulses", err_total, 0)
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
